// File: rtl/pipeline_hazard_ctrl.sv
// Decode-stage sequencer: load-use stall, JMP squash and Cond_J resolution wait.
// Latency: outputs are combinational from current state and the IF/ID instruction.
// Backpressure: hold freezes all enables and state; HAZ_PERF_CNT_EN adds stall_cnt.
module pipeline_hazard_ctrl #(
  parameter int JMP_FLUSH = 1,
  parameter int CJ_LAT    = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [23:0] ins,
  input  logic        hold,
  input  logic        cond_taken,
  output logic        pc_en,
  output logic        ifid_en,
  output logic        bubble,
  output logic [1:0]  pc_sel,
  output logic [1:0]  state
`ifdef HAZ_PERF_CNT_EN
  ,
  output logic [15:0] stall_cnt
`endif
);

  typedef enum logic [1:0] {
    ST_RUN     = 2'b00,
    ST_FLUSH   = 2'b01,
    ST_CJ_WAIT = 2'b10
  } state_t;

  localparam logic [3:0] JMP_CNT = 4'(JMP_FLUSH - 1);
  localparam logic [3:0] CJ_CNT  = 4'(CJ_LAT - 1);

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       ld_valid_q, ld_valid_d;
  logic [4:0] ld_rw_q, ld_rw_d;

  // Instruction field decode
  logic [4:0] opcode, rw, ra, rb;
  logic       is_jmp, is_cj, is_ld, is_st, is_imm;
  logic       reads_ra, reads_rb, reads_rw, use_hit;
  logic       unused_ins;

  assign opcode = ins[23:19];
  assign rw     = ins[18:14];
  assign ra     = ins[13:9];
  assign rb     = ins[8:4];
  assign unused_ins = ^ins[3:0];

  assign is_jmp = (opcode == 5'b11000);
  assign is_cj  = (opcode[4:2] == 3'b111);
  assign is_ld  = (opcode == 5'b10100);
  assign is_st  = (opcode == 5'b10101);
  assign is_imm = ~ins[23] & ins[22];

  assign reads_ra = ~(is_jmp | is_cj);
  assign reads_rb = ~(is_jmp | is_cj | is_imm);
  assign reads_rw = is_st;

  // ld_rw is never zero while ld_valid is set, so r0 cannot stall
  assign use_hit = ld_valid_q & ((reads_ra & (ra == ld_rw_q)) |
                                 (reads_rb & (rb == ld_rw_q)) |
                                 (reads_rw & (rw == ld_rw_q)));

  assign state = state_q;

  // State, countdown and pending-load registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_RUN;
      cnt_q      <= 4'd0;
      ld_valid_q <= 1'b0;
      ld_rw_q    <= 5'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ld_valid_q <= ld_valid_d;
      ld_rw_q    <= ld_rw_d;
    end
  end

  // Next-state and output decode; reset forcing and hold take priority
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ld_valid_d = ld_valid_q;
    ld_rw_d    = ld_rw_q;
    pc_en      = 1'b0;
    ifid_en    = 1'b0;
    bubble     = 1'b0;
    pc_sel     = 2'b00;
    if (!reset) begin
      bubble = 1'b1;
    end else if (!hold) begin
      case (state_q)
        ST_RUN: begin
          ld_valid_d = is_ld & (rw != 5'd0);
          ld_rw_d    = rw;
          if (use_hit) begin
            // One-cycle stall; the load result is forwardable next cycle
            bubble     = 1'b1;
            ld_valid_d = 1'b0;
            ld_rw_d    = ld_rw_q;
          end else if (is_jmp) begin
            pc_sel  = 2'b01;
            pc_en   = 1'b1;
            ifid_en = 1'b1;
            state_d = ST_FLUSH;
            cnt_d   = JMP_CNT;
          end else if (is_cj) begin
            // Cond_J moves on to EX while fetch waits for the outcome
            state_d = ST_CJ_WAIT;
            cnt_d   = CJ_CNT;
          end else begin
            pc_en   = 1'b1;
            ifid_en = 1'b1;
          end
        end
        ST_FLUSH: begin
          pc_en      = 1'b1;
          ifid_en    = 1'b1;
          bubble     = 1'b1;
          ld_valid_d = 1'b0;
          if (cnt_q == 4'd0) state_d = ST_RUN;
          else               cnt_d   = cnt_q - 4'd1;
        end
        ST_CJ_WAIT: begin
          bubble     = 1'b1;
          ld_valid_d = 1'b0;
          if (cnt_q != 4'd0) begin
            cnt_d = cnt_q - 4'd1;
          end else begin
            pc_en   = 1'b1;
            ifid_en = 1'b1;
            if (cond_taken) begin
              pc_sel  = 2'b10;
              state_d = ST_FLUSH;
              cnt_d   = 4'd0;
            end else begin
              state_d = ST_RUN;
            end
          end
        end
        default: begin
          state_d = ST_RUN;
          cnt_d   = 4'd0;
        end
      endcase
    end
  end

`ifdef HAZ_PERF_CNT_EN
  logic [15:0] stall_cnt_q;
  assign stall_cnt = stall_cnt_q;

  // Saturating count of bubble cycles that were not frozen by hold
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      stall_cnt_q <= 16'd0;
    else if (bubble && !hold && stall_cnt_q != 16'hFFFF)
      stall_cnt_q <= stall_cnt_q + 16'd1;
  end
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl with default JMP_FLUSH=1, CJ_LAT=2.
// Outputs are packed as {pc_en, ifid_en, bubble, pc_sel, state} for comparison.
// Inputs change 1 time unit after the rising edge and are checked 1 unit later.
module tb_pipeline_hazard_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [23:0] ins;
  logic        hold;
  logic        cond_taken;
  logic        pc_en, ifid_en, bubble;
  logic [1:0]  pc_sel, state;
`ifdef HAZ_PERF_CNT_EN
  logic [15:0] stall_cnt;
`endif
  logic [6:0]  outs;

  int checks   = 0;
  int failures = 0;

  localparam logic [4:0] OP_ADD = 5'b00000;
  localparam logic [4:0] OP_IMM = 5'b01000;
  localparam logic [4:0] OP_LD  = 5'b10100;
  localparam logic [4:0] OP_ST  = 5'b10101;
  localparam logic [4:0] OP_JMP = 5'b11000;
  localparam logic [4:0] OP_CJ  = 5'b11100;

  // {pc_en, ifid_en, bubble, pc_sel, state}
  localparam logic [6:0] E_NORM   = 7'b1100000;
  localparam logic [6:0] E_STALL  = 7'b0010000;
  localparam logic [6:0] E_JMP    = 7'b1100100;
  localparam logic [6:0] E_FLUSH  = 7'b1110001;
  localparam logic [6:0] E_CJ     = 7'b0000000;
  localparam logic [6:0] E_WAIT   = 7'b0010010;
  localparam logic [6:0] E_TAKEN  = 7'b1111010;
  localparam logic [6:0] E_NTAKEN = 7'b1110010;
  localparam logic [6:0] E_HOLDW  = 7'b0000010;
  localparam logic [6:0] E_RST    = 7'b0010000;

  assign outs = {pc_en, ifid_en, bubble, pc_sel, state};

  pipeline_hazard_ctrl #(.JMP_FLUSH(1), .CJ_LAT(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .ins        (ins),
    .hold       (hold),
    .cond_taken (cond_taken),
    .pc_en      (pc_en),
    .ifid_en    (ifid_en),
    .bubble     (bubble),
    .pc_sel     (pc_sel),
    .state      (state)
`ifdef HAZ_PERF_CNT_EN
    ,
    .stall_cnt  (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [23:0] mk(input logic [4:0] op, input logic [4:0] rw,
                                     input logic [4:0] ra, input logic [4:0] rb);
    return {op, rw, ra, rb, 4'b0000};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; hold = 1'b0; cond_taken = 1'b0;
    ins = mk(OP_JMP, 5'd0, 5'd0, 5'd0);
    #2;
    checks++; if (outs !== E_RST) begin failures++; $display("FAIL reset_force outs=%b exp=%b", outs, E_RST); end
`ifdef HAZ_PERF_CNT_EN
    checks++; if (stall_cnt !== 16'd0) begin failures++; $display("FAIL reset_stall_cnt got=%0d exp=0", stall_cnt); end
`endif
    tick();
    checks++; if (outs !== E_RST) begin failures++; $display("FAIL reset_hold_edge outs=%b exp=%b", outs, E_RST); end
    ins = mk(OP_ADD, 5'd0, 5'd0, 5'd0);
    reset = 1'b1;
    #1;
    checks++; if (outs !== E_NORM) begin failures++; $display("FAIL reset_release outs=%b exp=%b", outs, E_NORM); end
    tick();
  endtask

  task automatic test_load_use();
    ins = mk(OP_LD, 5'd5, 5'd1, 5'd2); #1;
    checks++; if (outs !== E_NORM) begin failures++; $display("FAIL lu_ld outs=%b exp=%b", outs, E_NORM); end
    tick();
    ins = mk(OP_ADD, 5'd3, 5'd5, 5'd6); #1;
    checks++; if (outs !== E_STALL) begin failures++; $display("FAIL lu_stall outs=%b exp=%b", outs, E_STALL); end
    tick(); #1;
    checks++; if (outs !== E_NORM) begin failures++; $display("FAIL lu_redecode outs=%b exp=%b", outs, E_NORM); end
    tick();
    ins = mk(OP_ADD, 5'd0, 5'd0, 5'd0); #1;
    checks++; if (outs !== E_NORM) begin failures++; $display("FAIL lu_after outs=%b exp=%b", outs, E_NORM); end
    tick();
  endtask

  task automatic test_no_stall_cases();
    ins = mk(OP_LD, 5'd0, 5'd4, 5'd4); #1;
    checks++; if (outs !== E_NORM) begin failures++; $display("FAIL r0_ld outs=%b exp=%b", outs, E_NORM); end
    tick();
    ins = mk(OP_ADD, 5'd3, 5'd0, 5'd0); #1;
    checks++; if (outs !== E_NORM) begin failures++; $display("FAIL r0_use outs=%b exp=%b", outs, E_NORM); end
    tick();
    ins = mk(OP_LD, 5'd5, 5'd1, 5'd2); #1;
    tick();
    ins = mk(OP_IMM, 5'd3, 5'd1, 5'd5); #1;
    checks++; if (outs !== E_NORM) begin failures++; $display("FAIL imm_rb outs=%b exp=%b", outs, E_NORM); end
    tick();
    ins = mk(OP_LD, 5'd5, 5'd1, 5'd2); #1;
    tick();
    ins = mk(OP_ST, 5'd5, 5'd1, 5'd2); #1;
    checks++; if (outs !== E_STALL) begin failures++; $display("FAIL st_rw outs=%b exp=%b", outs, E_STALL); end
    tick(); #1;
    checks++; if (outs !== E_NORM) begin failures++; $display("FAIL st_redecode outs=%b exp=%b", outs, E_NORM); end
    tick();
  endtask

  task automatic test_back_to_back();
    ins = mk(OP_LD, 5'd5, 5'd1, 5'd2); #1;
    tick();
    ins = mk(OP_LD, 5'd7, 5'd5, 5'd2); #1;
    checks++; if (outs !== E_STALL) begin failures++; $display("FAIL ldld_stall outs=%b exp=%b", outs, E_STALL); end
    tick(); #1;
    checks++; if (outs !== E_NORM) begin failures++; $display("FAIL ldld_once outs=%b exp=%b", outs, E_NORM); end
    tick();
    ins = mk(OP_ADD, 5'd3, 5'd1, 5'd7); #1;
    checks++; if (outs !== E_STALL) begin failures++; $display("FAIL ldld_second_rb outs=%b exp=%b", outs, E_STALL); end
    tick(); #1;
    checks++; if (outs !== E_NORM) begin failures++; $display("FAIL ldld_second_clear outs=%b exp=%b", outs, E_NORM); end
    tick();
  endtask

  task automatic test_jmp();
    ins = mk(OP_LD, 5'd5, 5'd1, 5'd2); #1;
    tick();
    ins = mk(OP_JMP, 5'd5, 5'd5, 5'd5); #1;
    checks++; if (outs !== E_JMP) begin failures++; $display("FAIL jmp_c0 outs=%b exp=%b", outs, E_JMP); end
    tick();
    ins = mk(OP_ADD, 5'd5, 5'd5, 5'd5); #1;
    checks++; if (outs !== E_FLUSH) begin failures++; $display("FAIL jmp_c1 outs=%b exp=%b", outs, E_FLUSH); end
    tick(); #1;
    checks++; if (outs !== E_NORM) begin failures++; $display("FAIL jmp_c2 outs=%b exp=%b", outs, E_NORM); end
    tick();
  endtask

  task automatic test_cj();
    // Taken
    ins = mk(OP_CJ, 5'd0, 5'd0, 5'd0); cond_taken = 1'b0; #1;
    checks++; if (outs !== E_CJ) begin failures++; $display("FAIL cjt_c0 outs=%b exp=%b", outs, E_CJ); end
    tick(); #1;
    checks++; if (outs !== E_WAIT) begin failures++; $display("FAIL cjt_c1 outs=%b exp=%b", outs, E_WAIT); end
    tick();
    cond_taken = 1'b1; #1;
    checks++; if (outs !== E_TAKEN) begin failures++; $display("FAIL cjt_c2 outs=%b exp=%b", outs, E_TAKEN); end
    tick();
    cond_taken = 1'b0; ins = mk(OP_ADD, 5'd0, 5'd0, 5'd0); #1;
    checks++; if (outs !== E_FLUSH) begin failures++; $display("FAIL cjt_c3 outs=%b exp=%b", outs, E_FLUSH); end
    tick(); #1;
    checks++; if (outs !== E_NORM) begin failures++; $display("FAIL cjt_c4 outs=%b exp=%b", outs, E_NORM); end
    tick();
    // Not taken; cond_taken high before the final wait cycle must be ignored
    ins = mk(OP_CJ, 5'd0, 5'd0, 5'd0); #1;
    checks++; if (outs !== E_CJ) begin failures++; $display("FAIL cjn_c0 outs=%b exp=%b", outs, E_CJ); end
    tick();
    cond_taken = 1'b1; #1;
    checks++; if (outs !== E_WAIT) begin failures++; $display("FAIL cjn_c1 outs=%b exp=%b", outs, E_WAIT); end
    tick();
    cond_taken = 1'b0; #1;
    checks++; if (outs !== E_NTAKEN) begin failures++; $display("FAIL cjn_c2 outs=%b exp=%b", outs, E_NTAKEN); end
    tick();
    ins = mk(OP_ADD, 5'd0, 5'd0, 5'd0); #1;
    checks++; if (outs !== E_NORM) begin failures++; $display("FAIL cjn_c3 outs=%b exp=%b", outs, E_NORM); end
    tick();
  endtask

  task automatic test_hold();
    ins = mk(OP_CJ, 5'd0, 5'd0, 5'd0); cond_taken = 1'b0; #1;
    tick();
    hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (outs !== E_HOLDW) begin failures++; $display("FAIL hold_c%0d outs=%b exp=%b", i, outs, E_HOLDW); end
      tick();
    end
    hold = 1'b0; #1;
    checks++; if (outs !== E_WAIT) begin failures++; $display("FAIL hold_resume outs=%b exp=%b", outs, E_WAIT); end
    tick(); #1;
    checks++; if (outs !== E_NTAKEN) begin failures++; $display("FAIL hold_final outs=%b exp=%b", outs, E_NTAKEN); end
    tick();
    ins = mk(OP_ADD, 5'd0, 5'd0, 5'd0); #1;
    checks++; if (outs !== E_NORM) begin failures++; $display("FAIL hold_run outs=%b exp=%b", outs, E_NORM); end
    tick();
  endtask

  task automatic test_reset_mid_flush();
    ins = mk(OP_JMP, 5'd0, 5'd0, 5'd0); #1;
    tick();
    ins = mk(OP_ADD, 5'd0, 5'd0, 5'd0); #1;
    checks++; if (outs !== E_FLUSH) begin failures++; $display("FAIL rmf_flush outs=%b exp=%b", outs, E_FLUSH); end
    #1;
    reset = 1'b0; #1;
    checks++; if (outs !== E_RST) begin failures++; $display("FAIL rmf_async outs=%b exp=%b", outs, E_RST); end
`ifdef HAZ_PERF_CNT_EN
    checks++; if (stall_cnt !== 16'd0) begin failures++; $display("FAIL rmf_stall_cnt got=%0d exp=0", stall_cnt); end
`endif
    #1;
    reset = 1'b1; #1;
    checks++; if (outs !== E_NORM) begin failures++; $display("FAIL rmf_release outs=%b exp=%b", outs, E_NORM); end
    tick(); #1;
    checks++; if (outs !== E_NORM) begin failures++; $display("FAIL rmf_run outs=%b exp=%b", outs, E_NORM); end
    tick();
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_no_stall_cases();
    test_back_to_back();
    test_jmp();
    test_cj();
    test_hold();
    test_reset_mid_flush();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Sequencing controller for the 5-stage 8-bit pipeline.
- Inspects the 24-bit instruction held in the IF/ID register (decode stage).
- Drives PC enable, IF/ID enable, PC source select and the ID/EX bubble (NOP insert).
- Handles load-use stalls, unconditional-jump squash and conditional-jump resolution wait; sits beside the operand-forwarding logic in the decode stage.

Parameters:
- JMP_FLUSH, 1, bubble cycles after a JMP (range 1..15).
- CJ_LAT, 2, cycles from Cond_J leaving decode until cond_taken is valid (range 1..15).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- ins  in  24  instruction in IF/ID: opcode [23:19], RW [18:14], RA [13:9], RB [8:4], imm [8:1].
- hold  in  1  global freeze (memory busy).
- cond_taken  in  1  conditional-jump outcome from EX; sampled only on the final CJ_WAIT cycle.
- pc_en  out  1  PC update enable.
- ifid_en  out  1  IF/ID load enable.
- bubble  out  1  replace decoded instruction with NOP into ID/EX.
- pc_sel  out  2  00 = PC+1, 01 = jump target, 10 = branch target.
- state  out  2  RUN = 00, FLUSH = 01, CJ_WAIT = 10.

Behaviour:
- Decode:
  - JMP = opcode 11000; CJ = opcode 111xx; LD = 10100; ST = 10101; IMM = ~ins[23] & ins[22].
  - reads_ra = ~(JMP|CJ).
  - reads_rb = ~(JMP|CJ|IMM).
  - reads_rw = ST.
- Load-use registers: ld_valid (1 bit), ld_rw (5 bit).
  - use_hit = ld_valid & ((reads_ra & RA==ld_rw) | (reads_rb & RB==ld_rw) | (reads_rw & RW==ld_rw)).
- Reset (reset = 0, asynchronous):
  - state = RUN, cnt = 0, ld_valid = 0, ld_rw = 0.
  - Outputs forced while asserted: pc_en = 0, ifid_en = 0, bubble = 1, pc_sel = 00.
  - Normal operation resumes on the first clk edge after release.
- Outputs are combinational from state, cnt, ins, ld_valid, cond_taken and hold. Registers update on the rising edge.
- hold = 1 (priority over the FSM):
  - pc_en = 0, ifid_en = 0, bubble = 0, pc_sel = 00.
  - state, cnt, ld_valid and ld_rw unchanged.
- RUN:
  - use_hit: pc_en = 0, ifid_en = 0, bubble = 1. Clear ld_valid. Stay in RUN. This is a 1-cycle stall; the instruction re-decodes the next cycle with no hit.
  - JMP: pc_sel = 01, pc_en = 1, ifid_en = 1, bubble = 0. Next state FLUSH, cnt = JMP_FLUSH-1.
  - CJ: pc_en = 0, ifid_en = 0, bubble = 0 (CJ proceeds to EX). Next state CJ_WAIT, cnt = CJ_LAT-1.
  - Otherwise: pc_en = 1, ifid_en = 1, bubble = 0, pc_sel = 00.
  - ld_valid <= LD & (RW != 0). ld_rw <= RW.
- FLUSH:
  - pc_en = 1, ifid_en = 1, bubble = 1, pc_sel = 00. This squashes the wrong-path instruction.
  - ld_valid <= 0.
  - cnt == 0 → RUN; else cnt - 1.
- CJ_WAIT:
  - cnt != 0: pc_en = 0, ifid_en = 0, bubble = 1; cnt - 1.
  - cnt == 0, cond_taken = 1: pc_sel = 10, pc_en = 1, ifid_en = 1, bubble = 1. Next state FLUSH, cnt = 0 (one squash cycle).
  - cnt == 0, cond_taken = 0: pc_sel = 00, pc_en = 1, ifid_en = 1, bubble = 1. Next state RUN.
  - ld_valid <= 0.
- Register 0 never causes a stall.
- Back-to-back LD/LD with a dependency stalls once.
- JMP immediately after LD: no stall.
- Reset mid-FLUSH/CJ_WAIT: immediate return to RUN; the pending count is discarded.

Optional Feature:
- HAZ_PERF_CNT_EN defined:
  - Extra output stall_cnt [15:0], reset 0.
  - Increments on every edge where bubble = 1 and hold = 0 and reset = 1.
  - Saturates at 16'hFFFF.
- Undefined: the port and the counter are absent.

Test Plan:
- LD r5 (RW = 5) then ADD with RA = 5 → exactly one cycle pc_en = 0, ifid_en = 0, bubble = 1; the next cycle is normal with no stall.
- LD r0 then ADD with RA = 0 → no stall. Immediate op with ins[8:4] = 5 after LD r5 → no stall.
- JMP with JMP_FLUSH = 1 → cycle 0: pc_sel = 01, pc_en = 1; cycle 1: bubble = 1, state = 01; cycle 2: RUN.
- CJ with CJ_LAT = 2, cond_taken = 1 on the final wait → sequence bubble = 0, 1, 1, 1 over 4 cycles; pc_sel = 10 on the 3rd; back in RUN on the 5th. With cond_taken = 0: bubble = 0, 1, 1; RUN on the 4th.
- hold = 1 for 3 cycles during CJ_WAIT → all enables 0 and cnt frozen; the wait resumes where it left off.
- reset pulled low mid-FLUSH (asynchronous, between edges) → outputs go immediately to pc_en = 0, bubble = 1, state = 00. With HAZ_PERF_CNT_EN, stall_cnt = 0.
